dds_spi_config: RTL and testbench

DDS_SPI_CONFIG -- requirements
Module: dds_spi_config

---
 rtl/dds_spi_config_if.sv | 9 +
 rtl/dds_spi_config.sv | 137 +++++++++++++
 tb/tb_dds_spi_config.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dds_spi_config_if.sv
// Pre-synchronized SPI bus feeding the DDS configuration block.
interface dds_spi_config_if;
  logic spi_clock;
  logic spi_cs_n;
  logic spi_mosi;

  modport master (output spi_clock, output spi_cs_n, output spi_mosi);
  modport slave  (input  spi_clock, input  spi_cs_n, input  spi_mosi);
endinterface

// File: rtl/dds_spi_config.sv
// SPI mode-0 configuration port for a DDS: shadow/active frequency and phase
// banks, UPDATE strobe, control register and registered output selection.
module dds_spi_config #(
  parameter int FREQ_W  = 16,
  parameter int PHASE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dds_spi_config_if.slave     spi,
  input  logic                fselect,
  input  logic                pselect,
  output logic [FREQ_W-1:0]   freq_word,
  output logic [PHASE_W-1:0]  phase_word,
  output logic                cfg_valid,
  output logic                frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC, HOLD} state_t;

  state_t              state, state_nx;
  logic                spi_prev;
  logic                spi_edge;
  logic [4:0]          bit_cnt;
  logic [23:0]         shreg;
  logic [3:0]          addr;
  logic [15:0]         data;
  logic                short_frame;
  logic                bad_addr;

  logic [FREQ_W-1:0]   sh_freq0, sh_freq1, act_freq0, act_freq1;
  logic [PHASE_W-1:0]  sh_phase0, sh_phase1, act_phase0, act_phase1;
  logic [2:0]          ctrl;
  logic                fsel, psel;
  logic [FREQ_W-1:0]   freq_nx;
  logic [PHASE_W-1:0]  phase_nx;

  assign spi_edge = spi.spi_clock & ~spi_prev;
  assign addr     = shreg[23:20];
  assign data     = shreg[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spi_prev <= 1'b0;
    end else begin
      state    <= state_nx;
      spi_prev <= spi.spi_clock;
    end
  end

  // cs_n dominates any edge seen in the same cycle
  always_comb begin
    state_nx    = state;
    short_frame = 1'b0;
    bad_addr    = 1'b0;
    case (state)
      IDLE:  if (!spi.spi_cs_n) state_nx = SHIFT;
      SHIFT: begin
        if (spi.spi_cs_n) begin
          state_nx    = IDLE;
          short_frame = (bit_cnt != 5'd0);
        end else if (spi_edge && bit_cnt == 5'd23) begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        state_nx = HOLD;
        bad_addr = (addr > 4'd5);
      end
      HOLD:  if (spi.spi_cs_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == IDLE && !spi.spi_cs_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == SHIFT && !spi.spi_cs_n && spi_edge) begin
      bit_cnt <= bit_cnt + 5'd1;
      shreg   <= {shreg[22:0], spi.spi_mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_freq0   <= '0;
      sh_freq1   <= '0;
      sh_phase0  <= '0;
      sh_phase1  <= '0;
      act_freq0  <= '0;
      act_freq1  <= '0;
      act_phase0 <= '0;
      act_phase1 <= '0;
      ctrl       <= '0;
    end else if (state == EXEC) begin
      case (addr)
        4'd0: sh_freq0  <= data[FREQ_W-1:0];
        4'd1: sh_freq1  <= data[FREQ_W-1:0];
        4'd2: sh_phase0 <= data[PHASE_W-1:0];
        4'd3: sh_phase1 <= data[PHASE_W-1:0];
        4'd4: begin
          act_freq0  <= sh_freq0;
          act_freq1  <= sh_freq1;
          act_phase0 <= sh_phase0;
          act_phase1 <= sh_phase1;
        end
        4'd5: ctrl <= data[2:0];
        default: ;
      endcase
    end
  end

  assign fsel     = ctrl[0] ? ctrl[1] : fselect;
  assign psel     = ctrl[0] ? ctrl[2] : pselect;
  assign freq_nx  = fsel ? act_freq1  : act_freq0;
  assign phase_nx = psel ? act_phase1 : act_phase0;

  // cfg_valid is aligned with the cycle the new output value appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_word  <= '0;
      phase_word <= '0;
      cfg_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      freq_word  <= freq_nx;
      phase_word <= phase_nx;
      cfg_valid  <= (freq_nx != freq_word) || (phase_nx != phase_word);
      frame_err  <= short_frame | bad_addr;
    end
  end

endmodule

// File: tb/tb_dds_spi_config.sv
// Scoreboard bench for dds_spi_config: directed SPI frames push expected
// output events; a monitor pops one per cfg_valid/frame_err pulse.
module tb_dds_spi_config;

  localparam int FREQ_W  = 16;
  localparam int PHASE_W = 8;

  typedef struct packed {
    logic               err;
    logic [FREQ_W-1:0]  f;
    logic [PHASE_W-1:0] p;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fselect = 1'b0;
  logic pselect = 1'b0;
  logic [FREQ_W-1:0]  freq_word;
  logic [PHASE_W-1:0] phase_word;
  logic cfg_valid, frame_err;

  int checks = 0;
  int errors = 0;
  ev_t sb[$];

  dds_spi_config_if spi ();

  dds_spi_config #(.FREQ_W(FREQ_W), .PHASE_W(PHASE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi.slave),
    .fselect    (fselect),
    .pselect    (pselect),
    .freq_word  (freq_word),
    .phase_word (phase_word),
    .cfg_valid  (cfg_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [FREQ_W-1:0] f, input logic [PHASE_W-1:0] p);
    ev_t e;
    e.err = err;
    e.f   = f;
    e.p   = p;
    sb.push_back(e);
  endtask

  task automatic spi_send(input logic [31:0] bits, input int nbits, input bit keep_cs);
    @(negedge clk);
    spi.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi  = bits[nbits-1-i];
      spi.spi_clock = 1'b0;
      repeat (2) @(negedge clk);
      spi.spi_clock = 1'b1;
      repeat (2) @(negedge clk);
    end
    spi.spi_clock = 1'b0;
    if (!keep_cs) begin
      @(negedge clk);
      spi.spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (cfg_valid || frame_err)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=valid%0b/err%0b freq=%h phase=%h required=none",
                   cfg_valid, frame_err, freq_word, phase_word);
        end else begin
          e = sb.pop_front();
          if (frame_err !== e.err || cfg_valid !== !e.err ||
              freq_word !== e.f || phase_word !== e.p) begin
            errors++;
            $display("FAIL sb_event actual=err%0b/valid%0b freq=%h phase=%h required=err%0b freq=%h phase=%h",
                     frame_err, cfg_valid, freq_word, phase_word, e.err, e.f, e.p);
          end
        end
      end
    end
  end

  initial begin
    spi.spi_cs_n  = 1'b1;
    spi.spi_clock = 1'b0;
    spi.spi_mosi  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_freq", 32'(freq_word), 32'h0);
    chk("rst_phase", 32'(phase_word), 32'h0);
    chk("rst_valid", 32'(cfg_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // FREQ0 then UPDATE
    spi_send(32'h001234, 24, 0);
    chk("shadow_no_effect0", 32'(freq_word), 32'h0);
    expect_ev(1'b0, 16'h1234, 8'h00);
    spi_send(32'h400000, 24, 0);

    // FREQ1 held in shadow until UPDATE, then selected by pin
    spi_send(32'h10ABCD, 24, 0);
    chk("shadow_no_effect1", 32'(freq_word), 32'h1234);
    spi_send(32'h400000, 24, 0);
    chk("update_unselected", 32'(freq_word), 32'h1234);
    expect_ev(1'b0, 16'hABCD, 8'h00);
    fselect = 1'b1;
    repeat (5) @(negedge clk);
    expect_ev(1'b0, 16'h1234, 8'h00);
    fselect = 1'b0;
    repeat (5) @(negedge clk);

    // PHASE1, UPDATE, CTRL src=reg psel=1
    spi_send(32'h300080, 24, 0);
    spi_send(32'h400000, 24, 0);
    chk("phase_pin_sel0", 32'(phase_word), 32'h00);
    expect_ev(1'b0, 16'h1234, 8'h80);
    spi_send(32'h500005, 24, 0);
    pselect = 1'b1;
    fselect = 1'b1;
    repeat (5) @(negedge clk);
    pselect = 1'b0;
    fselect = 1'b0;
    repeat (5) @(negedge clk);
    chk("reg_sel_phase", 32'(phase_word), 32'h80);
    chk("reg_sel_freq", 32'(freq_word), 32'h1234);

    // Short frame of 10 bits, then a normal CTRL frame back to pins
    expect_ev(1'b1, 16'h1234, 8'h80);
    spi_send(32'h0000015, 10, 0);
    chk("short_no_change", 32'(phase_word), 32'h80);
    expect_ev(1'b0, 16'h1234, 8'h00);
    spi_send(32'h500000, 24, 0);

    // Bad address
    expect_ev(1'b1, 16'h1234, 8'h00);
    spi_send(32'h90FFFF, 24, 0);
    chk("bad_addr_freq", 32'(freq_word), 32'h1234);

    // 30 edges: only first 24 count (FREQ0=5555)
    spi_send({2'b00, 24'h005555, 6'b111111}, 30, 0);
    expect_ev(1'b0, 16'h5555, 8'h00);
    spi_send(32'h400000, 24, 0);

    // Reset in the middle of a FREQ0 write
    spi_send(32'h00BEEF, 24, 0);
    spi_send(32'h00BEEF, 12, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_freq", 32'(freq_word), 32'h0);
    chk("midrst_phase", 32'(phase_word), 32'h0);
    spi.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_freq", 32'(freq_word), 32'h0);
    spi_send(32'h000777, 24, 0);
    expect_ev(1'b0, 16'h0777, 8'h00);
    spi_send(32'h400000, 24, 0);
    // PHASE0 data wider than PHASE_W is truncated
    spi_send(32'h2001FF, 24, 0);
    expect_ev(1'b0, 16'h0777, 8'hFF);
    spi_send(32'h400000, 24, 0);

    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
